// File: rtl/sar_scan_ctrl.sv
// Multi-channel successive-approximation ADC scan controller: sequences the
// analog mux, sample/hold, trial DAC and comparator for each enabled channel.
module sar_scan_ctrl #(
    parameter  int WIDTH         = 8,
    parameter  int CHANNELS      = 4,
    parameter  int SAMPLE_CYCLES = 2,
    parameter  int SETTLE_CYCLES = 0,
    localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic [CHANNELS-1:0] chan_mask,
    input  logic                cmp_in,
    output logic                sample,
    output logic [CW-1:0]       chan_sel,
    output logic [WIDTH-1:0]    dac_code,
    output logic                busy,
    output logic [WIDTH-1:0]    result,
    output logic [CW-1:0]       result_chan,
    output logic                result_valid,
    output logic                scan_done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SAMPLE  = 2'd1;
    localparam logic [1:0] S_CONVERT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES + 1) ? SAMPLE_CYCLES : SETTLE_CYCLES + 1;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(WIDTH);

    logic [1:0]          r_state;
    logic [CW-1:0]       r_chan;
    logic [CHANNELS-1:0] r_mask;
    logic                r_cont;
    logic                r_stop_pend;
    logic [CNTW-1:0]     r_cnt;
    logic [BW-1:0]       r_bit;
    logic [WIDTH-1:0]    r_code;
    logic [WIDTH-1:0]    r_result;
    logic [CW-1:0]       r_result_chan;

    logic [CW:0]         w_first;
    logic [CW:0]         w_next;
    logic [CW:0]         w_restart;
    logic                w_stop;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [CW:0] find_chan(input logic [CHANNELS-1:0] mask, input int from);
        logic [CW:0] r;
        r = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) r = {1'b1, CW'(i)};
        end
        return r;
    endfunction

    assign w_first   = find_chan(chan_mask, 0);
    assign w_next    = find_chan(r_mask, int'(r_chan) + 1);
    assign w_restart = find_chan(r_mask, 0);
    assign w_stop    = r_stop_pend | stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_chan        <= '0;
            r_mask        <= '0;
            r_cont        <= 1'b0;
            r_stop_pend   <= 1'b0;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_code        <= '0;
            r_result      <= '0;
            r_result_chan <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_stop_pend <= 1'b0;
                    if (start && !stop && w_first[CW]) begin
                        r_state <= S_SAMPLE;
                        r_chan  <= w_first[CW-1:0];
                        r_mask  <= chan_mask;
                        r_cont  <= continuous;
                        r_cnt   <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (r_cnt == CNTW'(SAMPLE_CYCLES - 1)) begin
                        r_state <= S_CONVERT;
                        r_cnt   <= '0;
                        r_bit   <= BW'(WIDTH - 1);
                        r_code  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CONVERT: begin
                    if (stop) r_stop_pend <= 1'b1;
                    // Comparator is sampled on the edge that closes the trial.
                    if (r_cnt == CNTW'(SETTLE_CYCLES)) begin
                        r_cnt         <= '0;
                        r_code[r_bit] <= cmp_in;
                        if (r_bit == '0) begin
                            r_state       <= S_DONE;
                            r_result      <= {r_code[WIDTH-1:1], cmp_in};
                            r_result_chan <= r_chan;
                        end else begin
                            r_bit <= r_bit - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                    if (w_stop) begin
                        r_state     <= S_IDLE;
                        r_stop_pend <= 1'b0;
                    end else if (w_next[CW]) begin
                        r_state <= S_SAMPLE;
                        r_chan  <= w_next[CW-1:0];
                    end else if (r_cont) begin
                        r_state <= S_SAMPLE;
                        r_chan  <= w_restart[CW-1:0];
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign sample       = (r_state == S_SAMPLE);
    assign chan_sel     = r_chan;
    assign dac_code     = (r_state == S_CONVERT) ? (r_code | (WIDTH'(1) << r_bit)) : '0;
    assign busy         = (r_state != S_IDLE);
    assign result       = r_result;
    assign result_chan  = r_result_chan;
    assign result_valid = (r_state == S_DONE);
    assign scan_done    = (r_state == S_DONE) && !w_next[CW];

endmodule

// File: doc/sar_scan_ctrl.md
# sar_scan_ctrl

Parametrised successive-approximation ADC controller for a multi-channel analog front end. It sequences an external analog mux, sample/hold switch, trial DAC and comparator to convert every enabled channel to a WIDTH-bit code. It supports single-scan and continuous-scan modes and configurable sample and DAC-settle times. It is the generalised successor of the fixed 8-bit, single-channel, one-bit-per-cycle SAR controller, and sits between the analog pads and the digital result consumer.

## Interface
- WIDTH, 8: result/DAC code width (2..16)
- CHANNELS, 4: number of analog channels (1..16); CW = max(1, clog2(CHANNELS))
- SAMPLE_CYCLES, 2: cycles sample is held high per channel (≥1)
- SETTLE_CYCLES, 0: extra DAC settle cycles per bit trial (≥0)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a scan; honoured only in IDLE
- stop  in  1  continuous mode: finish current channel, then go IDLE
- continuous  in  1  latched at start: 1 = wrap scan indefinitely
- chan_mask  in  CHANNELS  enabled channels, latched at start
- cmp_in  in  1  comparator: 1 = input ≥ dac_code (keep trial bit)
- sample  out  1  sample/hold switch closed
- chan_sel  out  CW  analog mux select
- dac_code  out  WIDTH  trial code to DAC
- busy  out  1  high in any state other than IDLE
- result  out  WIDTH  last completed code, held until next completion
- result_chan  out  CW  channel of result
- result_valid  out  1  one-cycle pulse per completed conversion
- scan_done  out  1  one-cycle pulse, coincident with result_valid of last enabled channel in a pass

## Operation
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE: start=1, stop=0 and latched mask ≠ 0 → SAMPLE on lowest set mask bit. Mask = 0 → start ignored. start and stop both high → start ignored.
- SAMPLE: sample=1, dac_code=0, chan_sel = current channel, for SAMPLE_CYCLES cycles → CONVERT.
- CONVERT: bit index k from WIDTH-1 down to 0.
  - Each trial: dac_code = decided bits | (1<<k), held SETTLE_CYCLES+1 cycles.
  - cmp_in is sampled on the edge ending the trial; bit k = cmp_in.
  - After k=0 → DONE.
- DONE (1 cycle): result/result_chan update, result_valid=1, dac_code=0.
  - Next higher set mask bit exists → SAMPLE on that channel.
  - Otherwise end of pass, scan_done=1: continuous=1 and no pending stop → SAMPLE on lowest set bit; else → IDLE.
- stop: a one-cycle pulse is latched as a pending request in any non-IDLE state. It is honoured at the next DONE, which goes to IDLE after the current channel regardless of pass position. Pending stop clears on entry to IDLE. Ignored in single mode beyond the same effect.
- Mid-scan changes to chan_mask or continuous are ignored until the next start.
- No backpressure: the consumer must capture result on result_valid.

## Timing
- Reset (async assert) forces immediately: state IDLE, sample=0, chan_sel=0, dac_code=0, busy=0, result=0, result_chan=0, result_valid=0, scan_done=0, pending stop cleared. Deassertion is synchronous to clk.
- start is sampled at edge E. From E+1: SAMPLE for SAMPLE_CYCLES cycles, then WIDTH×(SETTLE_CYCLES+1) CONVERT cycles, then 1 DONE cycle.
- Per-channel period P = SAMPLE_CYCLES + WIDTH×(SETTLE_CYCLES+1) + 1. Defaults: P = 11.
- Back-to-back channels: the next SAMPLE begins the cycle after DONE, with no idle gap.
- busy rises the cycle after start is sampled and falls the cycle after the final DONE.
- Reset mid-conversion: no result_valid is produced, and result reverts to 0.

## Test plan
- Defaults, mask=0001, single, comparator model cmp_in = (vin ≥ dac_code), vin=0x5A.
  - dac_code sequence: 80,40,60,50,58,5C,5A,5B.
  - result=0x5A, result_chan=0.
  - result_valid and scan_done pulse together 11 cycles after start.
- Extremes, mask=0001: vin=0x00 → result 0x00; vin=0xFF → result 0xFF. vin=0x80 → result 0x80 (equality keeps bit).
- mask=1010, single, vin ch1=0x33, ch3=0xC4.
  - Results (1,0x33) then (3,0xC4), 11 cycles apart.
  - scan_done pulses only with ch3; then busy=0.
- mask=1001, continuous, vin ch0=0x10, ch3=0xEF.
  - Channel order 0,3,0,3…, with scan_done every ch3.
  - stop pulsed during second ch3 CONVERT → that conversion completes with 0xEF, then IDLE.
- Abort and ignored starts:
  - rst asserted during trial of bit 4 → all outputs 0 in the same cycle, no result_valid.
  - start after release converts normally.
  - start with mask=0000 → busy stays 0.
  - start and stop asserted together → busy stays 0.
- SETTLE_CYCLES=2, SAMPLE_CYCLES=1, vin=0x5A.
  - Each dac_code is held 3 cycles.
  - result_valid arrives 1+24+1=26 cycles after start, result=0x5A.
